// File: rtl/vx_tcu_sequencer_if.sv
`timescale 1ns/1ps
// Signal bundle between the TCU sequencer (master) and the dispatch slot, LSU,
// tensor unit and commit stage around it (slave).
interface vx_tcu_sequencer_if #(
    parameter int TILE_WORDS = 4,
    parameter int WID_W      = 2
);
    localparam int IDX_W = (TILE_WORDS > 1) ? $clog2(TILE_WORDS) : 1;

    logic             req_valid;
    logic             req_ready;
    logic [WID_W-1:0] req_wid;
    logic [31:0]      req_addr_a;
    logic [31:0]      req_addr_b;
    logic [31:0]      req_addr_c;

    logic             lsu_req_valid;
    logic             lsu_req_ready;
    logic             lsu_req_rw;
    logic [31:0]      lsu_req_addr;
    logic [31:0]      lsu_req_data;
    logic             lsu_rsp_valid;
    logic [31:0]      lsu_rsp_data;

    logic             tu_in_valid;
    logic [31:0]      tu_in_a;
    logic [31:0]      tu_in_b;
    logic             tu_exec_start;
    logic             tu_exec_done;
    logic [IDX_W-1:0] tu_out_idx;
    logic [31:0]      tu_out_data;

    logic             cmt_valid;
    logic             cmt_ready;
    logic [WID_W-1:0] cmt_wid;
    logic             busy;

    modport master (
        input  req_valid, req_wid, req_addr_a, req_addr_b, req_addr_c,
               lsu_req_ready, lsu_rsp_valid, lsu_rsp_data,
               tu_exec_done, tu_out_data, cmt_ready,
        output req_ready, lsu_req_valid, lsu_req_rw, lsu_req_addr, lsu_req_data,
               tu_in_valid, tu_in_a, tu_in_b, tu_exec_start, tu_out_idx,
               cmt_valid, cmt_wid, busy
    );

    modport slave (
        output req_valid, req_wid, req_addr_a, req_addr_b, req_addr_c,
               lsu_req_ready, lsu_rsp_valid, lsu_rsp_data,
               tu_exec_done, tu_out_data, cmt_ready,
        input  req_ready, lsu_req_valid, lsu_req_rw, lsu_req_addr, lsu_req_data,
               tu_in_valid, tu_in_a, tu_in_b, tu_exec_start, tu_out_idx,
               cmt_valid, cmt_wid, busy
    );
endinterface

// File: rtl/vx_tcu_sequencer.sv
`timescale 1ns/1ps
// Single-instruction tile-MMA sequencer: loads A/B through the LSU, feeds the tensor
// unit, runs it, stores C back and commits the issuing warp.
module vx_tcu_sequencer #(
    parameter int TILE_WORDS = 4,
    parameter int WID_W      = 2
) (
    input  logic               clk,
    input  logic               reset,
    vx_tcu_sequencer_if.master bus
);
    localparam int IDX_W = (TILE_WORDS > 1) ? $clog2(TILE_WORDS) : 1;
    localparam int K_W   = $clog2(2 * TILE_WORDS);

    localparam logic [K_W-1:0] K_A_LAST  = K_W'(TILE_WORDS - 1);
    localparam logic [K_W-1:0] K_B_FIRST = K_W'(TILE_WORDS);
    localparam logic [K_W-1:0] K_B_LAST  = K_W'(2 * TILE_WORDS - 1);
    localparam logic [K_W-1:0] K_ONE     = K_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FEED,
        S_EXEC,
        S_STORE,
        S_COMMIT
    } state_e;

    state_e           state_q;
    logic [K_W-1:0]   k_q;
    logic             pend_q;
    logic             start_q;
    logic [WID_W-1:0] wid_q;
    logic [31:0]      addr_a_q;
    logic [31:0]      addr_b_q;
    logic [31:0]      addr_c_q;
    logic [31:0]      a_buf_q [TILE_WORDS];
    logic [31:0]      b_buf_q [TILE_WORDS];

    logic             in_b;
    logic [K_W-1:0]   k_d;
    logic [IDX_W-1:0] a_idx;
    logic [IDX_W-1:0] b_idx;
    logic [31:0]      base_sel;
    logic [K_W-1:0]   word_sel;

    assign in_b  = (k_q >= K_B_FIRST);
    assign k_d   = k_q + K_ONE;
    assign a_idx = IDX_W'(k_q);
    assign b_idx = IDX_W'(k_q - K_B_FIRST);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no case path infers a latch.
        base_sel           = '0;
        word_sel           = '0;
        bus.req_ready      = reset && (state_q == S_IDLE);
        bus.lsu_req_valid  = 1'b0;
        bus.lsu_req_rw     = 1'b0;
        bus.lsu_req_data   = '0;
        bus.tu_in_valid    = 1'b0;
        bus.tu_in_a        = '0;
        bus.tu_in_b        = '0;
        bus.tu_exec_start  = start_q;
        bus.tu_out_idx     = '0;
        bus.cmt_valid      = 1'b0;
        bus.cmt_wid        = '0;
        bus.busy           = (state_q != S_IDLE);
        case (state_q)
            S_LOAD: begin
                bus.lsu_req_valid = !pend_q;
                base_sel          = in_b ? addr_b_q : addr_a_q;
                word_sel          = in_b ? (k_q - K_B_FIRST) : k_q;
            end
            S_FEED: begin
                bus.tu_in_valid = 1'b1;
                bus.tu_in_a     = a_buf_q[a_idx];
                bus.tu_in_b     = b_buf_q[a_idx];
            end
            S_STORE: begin
                bus.lsu_req_valid = !pend_q;
                bus.lsu_req_rw    = 1'b1;
                bus.tu_out_idx    = a_idx;
                bus.lsu_req_data  = bus.tu_out_data;
                base_sel          = addr_c_q;
                word_sel          = k_q;
            end
            S_COMMIT: begin
                bus.cmt_valid = 1'b1;
                bus.cmt_wid   = wid_q;
            end
            default: ;
        endcase
        // Outside LOAD/STORE both terms are zero, so the address bus idles at 0.
        bus.lsu_req_addr = base_sel + (32'(word_sel) << 2);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            pend_q   <= 1'b0;
            start_q  <= 1'b0;
            wid_q    <= '0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            addr_c_q <= '0;
            // NOTE: the operand buffers are only a few words and must read as zero after reset, so they are cleared like any other register.
            for (int i = 0; i < TILE_WORDS; i++) begin
                a_buf_q[i] <= '0;
                b_buf_q[i] <= '0;
            end
        end else begin
            start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        wid_q    <= bus.req_wid;
                        addr_a_q <= bus.req_addr_a;
                        addr_b_q <= bus.req_addr_b;
                        addr_c_q <= bus.req_addr_c;
                        k_q      <= '0;
                        pend_q   <= 1'b0;
                        state_q  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (!pend_q) begin
                        if (bus.lsu_req_ready) pend_q <= 1'b1;
                    end else if (bus.lsu_rsp_valid) begin
                        if (in_b) b_buf_q[b_idx] <= bus.lsu_rsp_data;
                        else      a_buf_q[a_idx] <= bus.lsu_rsp_data;
                        pend_q <= 1'b0;
                        if (k_q == K_B_LAST) begin
                            k_q     <= '0;
                            state_q <= S_FEED;
                        end else begin
                            k_q <= k_d;
                        end
                    end
                end
                S_FEED: begin
                    if (k_q == K_A_LAST) begin
                        k_q     <= '0;
                        start_q <= 1'b1;
                        state_q <= S_EXEC;
                    end else begin
                        k_q <= k_d;
                    end
                end
                S_EXEC: begin
                    // A done seen in the start cycle belongs to no execution of ours.
                    if (!start_q && bus.tu_exec_done) begin
                        k_q     <= '0;
                        state_q <= S_STORE;
                    end
                end
                S_STORE: begin
                    if (!pend_q) begin
                        if (bus.lsu_req_ready) pend_q <= 1'b1;
                    end else if (bus.lsu_rsp_valid) begin
                        pend_q <= 1'b0;
                        if (k_q == K_A_LAST) begin
                            k_q     <= '0;
                            state_q <= S_COMMIT;
                        end else begin
                            k_q <= k_d;
                        end
                    end
                end
                S_COMMIT: begin
                    if (bus.cmt_ready) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vx_tcu_sequencer.sv
`timescale 1ns/1ps
// Directed bench for vx_tcu_sequencer: a transaction-level model predicts every LSU
// request, operand pair and commit, and a negedge process compares them each cycle.
module tb_vx_tcu_sequencer;
    localparam int T = 4;

    typedef struct packed {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] data;
    } lsu_txn_t;

    logic clk;
    logic reset;
    vx_tcu_sequencer_if #(.TILE_WORDS(T), .WID_W(2)) bus_if ();

    vx_tcu_sequencer #(.TILE_WORDS(T), .WID_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] c_mem [T];
    assign bus_if.tu_out_data = c_mem[bus_if.tu_out_idx];

    int n_pass = 0;
    int n_checks = 0;
    int cyc = 0;
    bit chk_en = 0;
    bit prev_rst_low = 1;

    // Model state
    lsu_txn_t    exp_req [$];
    logic [63:0] exp_feed [$];
    logic [1:0]  exp_wid [$];
    logic [31:0] ld_log [$];
    logic [63:0] feed_log [$];
    bit          m_busy = 0, m_out = 0, prev_stall = 0;
    lsu_txn_t    prev_req;
    int n_cmt = 0, n_start = 0, t_start = -1, t_store = -1, t_cmt = -1;

    // Environment (LSU / tensor unit / commit) state
    bit          rsp_pend = 0, rsp_is_ld = 0, spur = 0, done_always = 0;
    logic [31:0] rsp_data_q = '0, cfg_base = '0;
    int n_ld_req = 0, n_ld_rsp = 0, bp_idx = -1, bp_left = 0, cmt_left = 0, done_at = -1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [255:0] outs_vec();
        return 256'({bus_if.lsu_req_valid, bus_if.lsu_req_rw, bus_if.lsu_req_addr,
                     bus_if.lsu_req_data, bus_if.tu_in_valid, bus_if.tu_in_a, bus_if.tu_in_b,
                     bus_if.tu_exec_start, bus_if.tu_out_idx, bus_if.cmt_valid,
                     bus_if.cmt_wid, bus_if.busy});
    endfunction

    // One clock: advance, then play the LSU, tensor unit and commit stage for the new cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        bus_if.lsu_rsp_valid = rsp_pend || spur;
        bus_if.lsu_rsp_data  = rsp_pend ? rsp_data_q : (spur ? 32'hDEAD_BEEF : 32'h0);
        if (rsp_pend && rsp_is_ld) n_ld_rsp++;
        rsp_pend = 0;
        spur     = 0;
        if (bus_if.lsu_req_valid && !bus_if.lsu_req_rw && n_ld_req == bp_idx && bp_left > 0) begin
            bus_if.lsu_req_ready = 1'b0;
            bp_left--;
        end else begin
            bus_if.lsu_req_ready = 1'b1;
        end
        if (bus_if.lsu_req_valid && bus_if.lsu_req_ready) begin
            rsp_pend   = 1;
            rsp_is_ld  = !bus_if.lsu_req_rw;
            rsp_data_q = bus_if.lsu_req_rw ? 32'h0 : cfg_base + 32'(n_ld_req);
            if (!bus_if.lsu_req_rw) n_ld_req++;
        end
        bus_if.tu_exec_done = done_always || (cyc == done_at);
        if (bus_if.tu_exec_start) done_at = cyc + 3;
        if (bus_if.cmt_valid && cmt_left > 0) begin
            bus_if.cmt_ready = 1'b0;
            cmt_left--;
        end else begin
            bus_if.cmt_ready = 1'b1;
        end
    endtask

    // Compare process
    always @(negedge clk) begin
        if (chk_en) begin
            if (prev_rst_low) check("reset_state_outputs", outs_vec(), '0);
            if (!reset) begin
                check("req_ready_in_reset", bus_if.req_ready, 1'b0);
                exp_req.delete();
                exp_feed.delete();
                exp_wid.delete();
                m_busy = 0;
                m_out = 0;
                prev_stall = 0;
            end else begin
                check("busy", bus_if.busy, m_busy);
                check("req_ready", bus_if.req_ready, !m_busy);
                if (!m_busy)
                    check("idle_quiet", {bus_if.lsu_req_valid, bus_if.tu_in_valid,
                                         bus_if.tu_exec_start, bus_if.cmt_valid}, 4'b0);
                if (m_out) check("one_outstanding", bus_if.lsu_req_valid, 1'b0);
                if (prev_stall)
                    check("lsu_req_stable", {bus_if.lsu_req_valid, bus_if.lsu_req_rw,
                                             bus_if.lsu_req_addr, bus_if.lsu_req_data},
                          {1'b1, prev_req});
                if (m_out && bus_if.lsu_rsp_valid) m_out = 0;
                if (bus_if.lsu_req_valid && bus_if.lsu_req_rw && t_store < 0) t_store = cyc;
                if (bus_if.lsu_req_valid && bus_if.lsu_req_ready) begin
                    if (exp_req.size() == 0) check("lsu_req_unexpected", 1'b1, 1'b0);
                    else check("lsu_req", {bus_if.lsu_req_rw, bus_if.lsu_req_addr,
                                           bus_if.lsu_req_data}, exp_req.pop_front());
                    if (!bus_if.lsu_req_rw) ld_log.push_back(bus_if.lsu_req_addr);
                    m_out = 1;
                end
                if (bus_if.tu_in_valid) begin
                    feed_log.push_back({bus_if.tu_in_a, bus_if.tu_in_b});
                    if (exp_feed.size() == 0) check("feed_unexpected", 1'b1, 1'b0);
                    else check("feed_pair", {bus_if.tu_in_a, bus_if.tu_in_b}, exp_feed.pop_front());
                end
                if (bus_if.tu_exec_start) begin
                    n_start++;
                    t_start = cyc;
                end
                if (bus_if.cmt_valid && bus_if.cmt_ready) begin
                    if (exp_wid.size() == 0) check("cmt_unexpected", 1'b1, 1'b0);
                    else check("cmt_wid", bus_if.cmt_wid, exp_wid.pop_front());
                    check("exec_start_pulses", n_start, 1);
                    n_cmt++;
                    t_cmt = cyc;
                    m_busy = 0;
                end
                if (bus_if.req_valid && bus_if.req_ready) begin
                    for (int i = 0; i < T; i++)
                        exp_req.push_back('{rw: 1'b0, addr: bus_if.req_addr_a + 32'(4 * i), data: 32'h0});
                    for (int i = 0; i < T; i++)
                        exp_req.push_back('{rw: 1'b0, addr: bus_if.req_addr_b + 32'(4 * i), data: 32'h0});
                    for (int i = 0; i < T; i++)
                        exp_req.push_back('{rw: 1'b1, addr: bus_if.req_addr_c + 32'(4 * i), data: c_mem[i]});
                    for (int i = 0; i < T; i++)
                        exp_feed.push_back({cfg_base + 32'(i), cfg_base + 32'(T + i)});
                    exp_wid.push_back(bus_if.req_wid);
                    ld_log.delete();
                    feed_log.delete();
                    n_start = 0;
                    t_store = -1;
                    m_busy = 1;
                end
                prev_stall = bus_if.lsu_req_valid && !bus_if.lsu_req_ready;
                prev_req   = '{rw: bus_if.lsu_req_rw, addr: bus_if.lsu_req_addr, data: bus_if.lsu_req_data};
            end
            prev_rst_low = !reset;
        end
    end

    task automatic issue(input logic [1:0] wid, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] base, output int t_acc);
        cfg_base = base;
        for (int i = 0; i < T; i++) c_mem[i] = (base << 16) ^ 32'hC0DE_0000 ^ 32'(i * 3 + 1);
        n_ld_req = 0;
        n_ld_rsp = 0;
        bus_if.req_wid    = wid;
        bus_if.req_addr_a = a;
        bus_if.req_addr_b = b;
        bus_if.req_addr_c = c;
        bus_if.req_valid  = 1'b1;
        for (int w = 0; w < 20 && !bus_if.req_ready; w++) tick();
        check("req_accept", bus_if.req_ready, 1'b1);
        t_acc = cyc;
        tick();
        bus_if.req_valid = 1'b0;
    endtask

    task automatic finish_txn(input int t_acc, input bit spur_feed, output int lat);
        int  n0 = n_cmt;
        bit  spur_done = 0;
        for (int w = 0; w < 400 && n_cmt == n0; w++) begin
            tick();
            if (spur_feed && !spur_done && bus_if.tu_in_valid) begin
                bus_if.lsu_rsp_valid = 1'b1;
                bus_if.lsu_rsp_data  = 32'hBAD0_BAD0;
                spur_done = 1;
            end
        end
        check("commit_seen", n_cmt, n0 + 1);
        lat = t_cmt - t_acc;
        check("req_ready_after_cmt", {bus_if.req_ready, 32'(cyc - t_cmt)}, {1'b1, 32'd1});
        check("model_drained", {32'(exp_req.size()), 32'(exp_feed.size()), 32'(exp_wid.size())}, '0);
    endtask

    initial begin
        int t_acc, lat, n0;
        bit hit;
        reset = 1'b0;
        bus_if.req_valid = 1'b0; bus_if.req_wid = '0;
        bus_if.req_addr_a = '0; bus_if.req_addr_b = '0; bus_if.req_addr_c = '0;
        bus_if.lsu_req_ready = 1'b1; bus_if.lsu_rsp_valid = 1'b0; bus_if.lsu_rsp_data = '0;
        bus_if.tu_exec_done = 1'b0; bus_if.cmt_ready = 1'b1;
        for (int i = 0; i < T; i++) c_mem[i] = '0;
        tick();
        chk_en = 1;
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Nominal transaction
        issue(2'd2, 32'h1000, 32'h2000, 32'h3000, 32'h10, t_acc);
        finish_txn(t_acc, 0, lat);
        check("nominal_latency", lat, 33);
        check("nominal_first_load", ld_log[0], 32'h1000);
        check("nominal_last_a_load", ld_log[3], 32'h100C);
        check("nominal_first_b_load", ld_log[4], 32'h2000);
        check("nominal_last_load", ld_log[7], 32'h200C);
        check("nominal_feed0", feed_log[0], {32'h10, 32'h14});
        check("nominal_feed3", feed_log[3], {32'h13, 32'h17});
        check("nominal_exec_to_store", t_store - t_start, 4);

        // LSU and commit back-pressure
        bp_idx = 2; bp_left = 5; cmt_left = 4;
        issue(2'd1, 32'h4000, 32'h5000, 32'h6000, 32'h20, t_acc);
        finish_txn(t_acc, 0, lat);
        check("backpressure_latency", lat, 42);
        check("backpressure_load2_addr", ld_log[2], 32'h4008);
        check("backpressure_feed2", feed_log[2], {32'h22, 32'h26});
        bp_idx = -1;

        // Spurious responses in IDLE and during FEED
        spur = 1;
        tick();
        check("spurious_idle_no_start", bus_if.busy, 1'b0);
        tick();
        issue(2'd3, 32'h7000, 32'h7100, 32'h7200, 32'h30, t_acc);
        finish_txn(t_acc, 1, lat);
        check("spurious_latency", lat, 33);
        check("spurious_feed1", feed_log[1], {32'h31, 32'h35});

        // Reset one cycle after the 5th load response, with a late response following
        issue(2'd0, 32'h8000, 32'h9000, 32'hA000, 32'h40, t_acc);
        hit = 0;
        for (int w = 0; w < 100 && !hit; w++) begin
            tick();
            hit = (n_ld_rsp == 5);
        end
        check("reset_test_fifth_rsp", hit, 1'b1);
        n0 = n_cmt;
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int w = 0; w < 6; w++) tick();
        check("reset_no_commit", n_cmt, n0);
        check("reset_idle_after", {bus_if.busy, bus_if.req_ready}, 2'b01);
        issue(2'd2, 32'h1000, 32'h2000, 32'h3000, 32'h50, t_acc);
        finish_txn(t_acc, 0, lat);
        check("post_reset_latency", lat, 33);
        check("post_reset_feed0", feed_log[0], {32'h50, 32'h54});

        // Address wrap on A (and on the C stores)
        issue(2'd1, 32'hFFFF_FFF8, 32'h0000_0100, 32'hFFFF_FFF0, 32'h60, t_acc);
        finish_txn(t_acc, 0, lat);
        check("wrap_load0", ld_log[0], 32'hFFFF_FFF8);
        check("wrap_load1", ld_log[1], 32'hFFFF_FFFC);
        check("wrap_load2", ld_log[2], 32'h0000_0000);
        check("wrap_load3", ld_log[3], 32'h0000_0004);

        // tu_exec_done held high for the whole execution
        done_always = 1;
        issue(2'd3, 32'hB000, 32'hC000, 32'hD000, 32'h70, t_acc);
        finish_txn(t_acc, 0, lat);
        done_always = 0;
        check("early_done_exec_to_store", t_store - t_start, 2);
        check("early_done_latency", lat, 31);

        tick();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
